// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and the iteration-counter width helper.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULTU = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_DIVU  = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } mdu_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mdu_cond_neg.sv
// Conditional two's-complement negation: out = neg ? -in : in. Purely combinational.
module mdu_cond_neg #(
  parameter int N = 32
) (
  input  logic [N-1:0] in_i,
  input  logic         neg_i,
  output logic [N-1:0] out_o
);

  assign out_o = neg_i ? -in_i : in_i;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO with HI/LO registers; WIDTH+2 cycle
// latency (2 for divide-by-zero). start is ignored while busy; abort returns to IDLE.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = clog2(WIDTH + 1);

  mdu_state_e       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] md_q, md_d;
  logic [WIDTH:0]   upper_q, upper_d;
  logic [WIDTH-1:0] lower_q, lower_d;
  logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic             dbz_q, dbz_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic               is_signed, is_div, b_zero;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     div_shift, add_x, add_y, add_r, mul_t;
  logic               borrow;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign is_signed = (op_q == MDU_MULT) || (op_q == MDU_DIV);
  assign is_div    = (op_q == MDU_DIVU) || (op_q == MDU_DIV);
  assign b_zero    = (b_q == '0);

  mdu_cond_neg #(.N(WIDTH)) u_mag_a (
    .in_i (a_q), .neg_i(is_signed & a_q[WIDTH-1]), .out_o(mag_a)
  );
  mdu_cond_neg #(.N(WIDTH)) u_mag_b (
    .in_i (b_q), .neg_i(is_signed & b_q[WIDTH-1]), .out_o(mag_b)
  );

  // One shared WIDTH+1 adder: accumulates for multiply, trial-subtracts for divide.
  assign div_shift = {upper_q[WIDTH-1:0], lower_q[WIDTH-1]};
  assign add_x     = is_div ? div_shift : upper_q;
  assign add_y     = {1'b0, md_q};
  assign add_r     = add_x + (add_y ^ {(WIDTH + 1){is_div}}) + {{WIDTH{1'b0}}, is_div};
  assign borrow    = add_r[WIDTH];
  assign mul_t     = lower_q[0] ? add_r : upper_q;

  mdu_cond_neg #(.N(2 * WIDTH)) u_fix_prod (
    .in_i (({upper_q[WIDTH-1:0], lower_q})), .neg_i(sign_a_q ^ sign_b_q), .out_o(prod_fix)
  );
  mdu_cond_neg #(.N(WIDTH)) u_fix_quo (
    .in_i (lower_q), .neg_i(sign_a_q ^ sign_b_q), .out_o(quo_fix)
  );
  mdu_cond_neg #(.N(WIDTH)) u_fix_rem (
    .in_i (upper_q[WIDTH-1:0]), .neg_i(sign_a_q), .out_o(rem_fix)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    md_d     = md_q;
    upper_d  = upper_q;
    lower_d  = lower_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dbz_d    = dbz_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          case (op_i)
            MDU_MULTU, MDU_MULT, MDU_DIVU, MDU_DIV: begin
              op_d    = op_i;
              a_d     = a_i;
              b_d     = b_i;
              state_d = PREP;
            end
            MDU_MTHI: hi_d = a_i;
            MDU_MTLO: lo_d = a_i;
            default: ;
          endcase
        end
      end
      PREP: begin
        sign_a_d = is_signed & a_q[WIDTH-1];
        sign_b_d = is_signed & b_q[WIDTH-1];
        cnt_d    = '0;
        upper_d  = '0;
        dbz_d    = is_div & b_zero;
        md_d     = is_div ? mag_b : mag_a;
        lower_d  = is_div ? mag_a : mag_b;
        state_d  = (is_div && b_zero) ? FIX : RUN;
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (is_div) begin
          upper_d = borrow ? div_shift : add_r;
          lower_d = {lower_q[WIDTH-2:0], ~borrow};
        end else begin
          upper_d = {1'b0, mul_t[WIDTH:1]};
          lower_d = {mul_t[0], lower_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        done_d  = 1'b1;
        dz_d    = dbz_q;
        state_d = IDLE;
        if (dbz_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else if (is_div) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over a FIX write landing on the same edge.
    if (abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
      done_d  = 1'b0;
      dz_d    = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      md_q     <= '0;
      upper_q  <= '0;
      lower_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dbz_q    <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      md_q     <= md_d;
      upper_q  <= upper_d;
      lower_q  <= lower_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dbz_q    <= dbz_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign div_by_zero_o = dz_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized + directed bench for mul_div_unit at WIDTH=32 and WIDTH=8 against an
// arithmetic reference model.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        start32, abort32, busy32, done32, dz32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        start8, abort8, busy8, done8, dz8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  mul_div_unit #(.WIDTH(32)) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start32), .op_i(op32), .a_i(a32), .b_i(b32),
    .abort_i(abort32), .busy_o(busy32), .done_o(done32), .div_by_zero_o(dz32),
    .hi_o(hi32), .lo_o(lo32)
  );
  mul_div_unit #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .op_i(op8), .a_i(a8), .b_i(b8),
    .abort_i(abort8), .busy_o(busy8), .done_o(done8), .div_by_zero_o(dz8),
    .hi_o(hi8), .lo_o(lo8)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi[2];
  logic [31:0] m_lo[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int idx(input int w);
    return (w == 8) ? 1 : 0;
  endfunction
  function automatic logic [31:0] mask(input int w);
    return (w == 8) ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction
  function automatic longint sx(input logic [31:0] v, input int w);
    if (w == 8) return longint'($signed(v[7:0]));
    return longint'($signed(v));
  endfunction

  function automatic logic busy_of(input int w); return (w == 8) ? busy8 : busy32; endfunction
  function automatic logic done_of(input int w); return (w == 8) ? done8 : done32; endfunction
  function automatic logic dz_of(input int w);   return (w == 8) ? dz8 : dz32;     endfunction
  function automatic logic [31:0] hi_of(input int w); return (w == 8) ? {24'b0, hi8} : hi32; endfunction
  function automatic logic [31:0] lo_of(input int w); return (w == 8) ? {24'b0, lo8} : lo32; endfunction

  task automatic drive(input int w, input logic st, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic ab);
    if (w == 8) begin
      start8 = st; op8 = op; a8 = a[7:0]; b8 = b[7:0]; abort8 = ab;
    end else begin
      start32 = st; op32 = op; a32 = a; b32 = b; abort32 = ab;
    end
  endtask

  // Reference: plain integer arithmetic on sign-extended or zero-extended operands.
  task automatic model(input int w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output logic dz,
                       output int lat, output logic mdop);
    logic [31:0] mk, aa, bb;
    logic [63:0] p, q, r;
    mk = mask(w);
    aa = a & mk;
    bb = b & mk;
    hi = m_hi[idx(w)];
    lo = m_lo[idx(w)];
    dz = 1'b0;
    lat = w + 2;
    mdop = 1'b1;
    case (op)
      3'd0, 3'd1: begin
        if (op == 3'd0) p = {32'b0, aa} * {32'b0, bb};
        else            p = sx(aa, w) * sx(bb, w);
        hi = 32'(p >> w) & mk;
        lo = p[31:0] & mk;
      end
      3'd2, 3'd3: begin
        if (bb == 0) begin
          dz = 1'b1; hi = aa; lo = mk; lat = 2;
        end else begin
          if (op == 3'd2) begin
            q = {32'b0, aa} / {32'b0, bb};
            r = {32'b0, aa} % {32'b0, bb};
          end else begin
            q = sx(aa, w) / sx(bb, w);
            r = sx(aa, w) % sx(bb, w);
          end
          lo = q[31:0] & mk;
          hi = r[31:0] & mk;
        end
      end
      3'd4: begin hi = aa; mdop = 1'b0; end
      3'd5: begin lo = aa; mdop = 1'b0; end
      default: mdop = 1'b0;
    endcase
  endtask

  task automatic run_op(input int w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input int stray_at, input int abort_at);
    logic [31:0] e_hi, e_lo;
    logic e_dz, mdop, busy_ok, seen;
    int lat, cyc;
    model(w, op, a, b, e_hi, e_lo, e_dz, lat, mdop);
    drive(w, 1'b1, op, a, b, 1'b0);
    @(posedge clk); #1;
    drive(w, 1'b0, 3'($urandom), $urandom, $urandom, 1'b0);
    if (!mdop) begin
      check({tag, "_busy"}, busy_of(w), 1'b0);
      check({tag, "_done"}, done_of(w), 1'b0);
      check({tag, "_hi"}, hi_of(w), e_hi);
      check({tag, "_lo"}, lo_of(w), e_lo);
      m_hi[idx(w)] = e_hi;
      m_lo[idx(w)] = e_lo;
      return;
    end
    cyc = 0;
    busy_ok = 1'b1;
    while (cyc < 200) begin
      if (!busy_of(w)) busy_ok = 1'b0;
      if (cyc == stray_at) drive(w, 1'b1, MDU_DIVU, 32'd100, 32'd7, 1'b0);
      if (cyc == abort_at) drive(w, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
      @(posedge clk); #1;
      cyc++;
      drive(w, 1'b0, 3'd0, $urandom, $urandom, 1'b0);
      if (abort_at >= 0 && cyc == abort_at + 1) begin
        check({tag, "_abort_busy"}, busy_of(w), 1'b0);
        seen = done_of(w);
        repeat (w + 4) begin
          @(posedge clk); #1;
          seen = seen | done_of(w) | busy_of(w);
        end
        check({tag, "_abort_quiet"}, seen, 1'b0);
        check({tag, "_abort_hi"}, hi_of(w), m_hi[idx(w)]);
        check({tag, "_abort_lo"}, lo_of(w), m_lo[idx(w)]);
        return;
      end
      if (done_of(w)) break;
    end
    check({tag, "_latency"}, cyc, lat);
    check({tag, "_busy_during"}, busy_ok, 1'b1);
    check({tag, "_busy_at_done"}, busy_of(w), 1'b0);
    check({tag, "_dbz"}, dz_of(w), e_dz);
    check({tag, "_hi"}, hi_of(w), e_hi);
    check({tag, "_lo"}, lo_of(w), e_lo);
    m_hi[idx(w)] = e_hi;
    m_lo[idx(w)] = e_lo;
  endtask

  function automatic logic [31:0] pick(input int w);
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return mask(w);
      2: return 32'd1 << (w - 1);
      3: return 32'd1;
      default: return $urandom & mask(w);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    drive(8, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin m_hi[i] = 32'd0; m_lo[i] = 32'd0; end
    #12;
    for (int k = 0; k < 2; k++) begin
      int w;
      w = (k == 0) ? 32 : 8;
      check("reset_busy", busy_of(w), 1'b0);
      check("reset_done", done_of(w), 1'b0);
      check("reset_dbz", dz_of(w), 1'b0);
      check("reset_hi", hi_of(w), 32'd0);
      check("reset_lo", lo_of(w), 32'd0);
    end
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(32, MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", -1, -1);
    check("multu_max_hi_k", hi32, 32'hFFFF_FFFE);
    check("multu_max_lo_k", lo32, 32'h0000_0001);
    run_op(32, MDU_MULT, 32'hFFFF_FFFD, 32'd7, "mult_neg", -1, -1);
    check("mult_neg_lo_k", lo32, 32'hFFFF_FFEB);
    run_op(32, MDU_DIVU, 32'd100, 32'd7, "divu_100_7", -1, -1);
    check("divu_lo_k", lo32, 32'd14);
    check("divu_hi_k", hi32, 32'd2);
    run_op(32, MDU_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg7_2", -1, -1);
    check("div_neg_lo_k", lo32, 32'hFFFF_FFFD);
    run_op(32, MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1", -1, -1);
    check("div_min_lo_k", lo32, 32'h8000_0000);
    run_op(32, MDU_DIV, 32'd5, 32'd0, "div_by_zero", -1, -1);
    check("dbz_hi_k", hi32, 32'd5);
    run_op(32, MDU_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, "stray_start", 5, -1);
    run_op(32, MDU_MULTU, 32'd7, 32'd9, "abort_run", -1, 10);
    run_op(32, MDU_MULT, 32'd3, 32'd5, "abort_fix", -1, 33);
    run_op(32, MDU_MTLO, 32'h1234, 32'd0, "mtlo", -1, -1);
    run_op(32, MDU_MTHI, 32'hCAFE, 32'd0, "mthi", -1, -1);
    run_op(32, 3'd6, 32'hDEAD, 32'hBEEF, "op6", -1, -1);

    run_op(8, MDU_MULTU, 32'hFF, 32'hFF, "w8_multu", -1, -1);
    run_op(8, MDU_MULT, 32'h80, 32'h80, "w8_mult", -1, -1);
    check("w8_mult_hi_k", hi8, 8'h40);
    run_op(8, MDU_DIVU, 32'd200, 32'd9, "w8_divu", -1, -1);
    run_op(8, MDU_DIV, 32'h80, 32'hFF, "w8_div_min", -1, -1);
    run_op(8, MDU_DIV, 32'hF9, 32'd2, "w8_div_neg", -1, -1);
    run_op(8, MDU_DIVU, 32'd3, 32'd4, "w8_abort_prep", -1, 0);

    for (int i = 0; i < 60; i++) begin
      int w;
      w = ($urandom_range(0, 1) == 0) ? 32 : 8;
      run_op(w, 3'($urandom_range(0, 7)), pick(w), pick(w), "rand", -1, -1);
    end

    drive(32, 1'b1, MDU_MULTU, 32'hFFFF, 32'hFFFF, 1'b0);
    @(posedge clk); #1;
    drive(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("areset_busy", busy32, 1'b0);
    check("areset_hi32", hi32, 32'd0);
    check("areset_lo32", lo32, 32'd0);
    check("areset_lo8", {24'b0, lo8}, 32'd0);
    for (int i = 0; i < 2; i++) begin m_hi[i] = 32'd0; m_lo[i] = 32'd0; end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_busy", busy32, 1'b0);
    run_op(32, MDU_DIVU, 32'd1000, 32'd33, "post_reset_divu", -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
